// File: rtl/synth_voice_engine.sv
// synth_voice_engine: allocates note events to a voice table, steps phase and ADSR per sample tick, mixes all voices.
// Optional macro VOICE_STEAL_EN: a note-on with no free voice steals one round-robin instead of being dropped.
module synth_voice_engine #(
  parameter int NUM_VOICES   = 8,
  parameter int PHASE_W      = 24,
  parameter int ENV_W        = 12,
  parameter int OUT_W        = 16,
  parameter int SAMPLE_DIV   = 667,
  parameter int ATTACK_RATE  = 32,
  parameter int DECAY_RATE   = 32,
  parameter int RELEASE_RATE = 8,
  parameter int SUSTAIN_LVL  = 2048
) (
  input  logic                    clk32,
  input  logic                    rst,
  input  logic                    evt_valid,
  output logic                    evt_ready,
  input  logic                    evt_on,
  input  logic [6:0]              evt_note,
  input  logic [3:0]              evt_chan,
  input  logic [6:0]              evt_vel,
  input  logic [PHASE_W-1:0]      evt_inc,
  output logic                    evt_drop,
  output logic signed [OUT_W-1:0] sample_out,
  output logic                    sample_valid,
  output logic [4:0]              voices_act
);

  localparam int VIDX_W = $clog2(NUM_VOICES);
  localparam int ACC_W  = 12 + VIDX_W;
  localparam int OUT_SH = OUT_W - ACC_W;
  localparam int CNT_W  = $clog2(SAMPLE_DIV);
  localparam int EW1    = ENV_W + 1;
  localparam int PROD_W = ENV_W + 13;
  localparam logic [ENV_W-1:0] ENV_FULL = '1;
  localparam logic [EW1-1:0] FULL_X = {1'b0, ENV_FULL};
  localparam logic [EW1-1:0] ATK_R  = EW1'(ATTACK_RATE);
  localparam logic [EW1-1:0] DEC_R  = EW1'(DECAY_RATE);
  localparam logic [EW1-1:0] REL_R  = EW1'(RELEASE_RATE);
  localparam logic [EW1-1:0] SUS_X  = EW1'(SUSTAIN_LVL);

  typedef enum logic [1:0] {ST_WAIT, ST_SCAN, ST_EMIT} eng_state_e;
  typedef enum logic [2:0] {V_IDLE, V_ATTACK, V_DECAY, V_SUSTAIN, V_RELEASE} voice_state_e;

  eng_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [VIDX_W-1:0]       vidx_q, vidx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic signed [OUT_W-1:0] sample_out_q, sample_out_d;
  logic                    sample_valid_q, sample_valid_d;
  logic                    evt_drop_q, evt_drop_d;
  logic [4:0]              voices_act_q, voices_act_d;

  voice_state_e      vst_q   [NUM_VOICES];
  voice_state_e      vst_d   [NUM_VOICES];
  logic [PHASE_W-1:0] phase_q [NUM_VOICES];
  logic [PHASE_W-1:0] phase_d [NUM_VOICES];
  logic [PHASE_W-1:0] inc_q   [NUM_VOICES];
  logic [PHASE_W-1:0] inc_d   [NUM_VOICES];
  logic [ENV_W-1:0]   env_q   [NUM_VOICES];
  logic [ENV_W-1:0]   env_d   [NUM_VOICES];
  logic [6:0]         note_q  [NUM_VOICES];
  logic [6:0]         note_d  [NUM_VOICES];
  logic [6:0]         vel_q   [NUM_VOICES];
  logic [6:0]         vel_d   [NUM_VOICES];
  logic [3:0]         chan_q  [NUM_VOICES];
  logic [3:0]         chan_d  [NUM_VOICES];
`ifdef VOICE_STEAL_EN
  logic [VIDX_W-1:0]  steal_ptr_q, steal_ptr_d;
`endif

  logic                     tick, evt_acc;
  logic signed [11:0]       saw, env_mix, contrib;
  logic signed [PROD_W-1:0] prod_env;
  logic signed [19:0]       prod_vel;
  logic [EW1-1:0]           env_ext;
  logic                     on_hit, free_hit, off_hit, init_en;
  logic [VIDX_W-1:0]        on_idx, free_idx, off_idx, init_idx;
  logic [4:0]               act_cnt;

  assign tick      = (cnt_q == CNT_W'(SAMPLE_DIV - 1));
  assign evt_ready = (state_q == ST_WAIT);
  assign evt_acc   = evt_valid && evt_ready;

  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign evt_drop     = evt_drop_q;
  assign voices_act   = voices_act_q;

  // Mix term of the voice under scan, from its pre-update phase and envelope
  always_comb begin
    saw      = phase_q[vidx_q][PHASE_W-1 -: 12];
    prod_env = PROD_W'(saw) * PROD_W'($signed({1'b0, env_q[vidx_q]}));
    env_mix  = 12'(prod_env >>> ENV_W);
    prod_vel = 20'(env_mix) * 20'($signed({1'b0, vel_q[vidx_q]}));
    contrib  = (vst_q[vidx_q] == V_IDLE) ? '0 : 12'(prod_vel >>> 7);
  end

  // Descending loop so the lowest matching index wins
  always_comb begin
    on_hit   = 1'b0;
    free_hit = 1'b0;
    off_hit  = 1'b0;
    on_idx   = '0;
    free_idx = '0;
    off_idx  = '0;
    act_cnt  = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (vst_q[i] != V_IDLE && note_q[i] == evt_note && chan_q[i] == evt_chan) begin
        on_hit = 1'b1;
        on_idx = VIDX_W'(i);
      end
      if (vst_q[i] == V_IDLE) begin
        free_hit = 1'b1;
        free_idx = VIDX_W'(i);
      end
      if (vst_q[i] inside {V_ATTACK, V_DECAY, V_SUSTAIN} &&
          note_q[i] == evt_note && chan_q[i] == evt_chan) begin
        off_hit = 1'b1;
        off_idx = VIDX_W'(i);
      end
      act_cnt = act_cnt + 5'(vst_q[i] != V_IDLE);
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = tick ? '0 : cnt_q + CNT_W'(1);
    vidx_d         = vidx_q;
    acc_d          = acc_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = 1'b0;
    evt_drop_d     = 1'b0;
    voices_act_d   = voices_act_q;
    vst_d          = vst_q;
    phase_d        = phase_q;
    inc_d          = inc_q;
    env_d          = env_q;
    note_d         = note_q;
    vel_d          = vel_q;
    chan_d         = chan_q;
`ifdef VOICE_STEAL_EN
    steal_ptr_d    = steal_ptr_q;
`endif
    env_ext        = {1'b0, env_q[vidx_q]};
    init_en        = 1'b0;
    init_idx       = '0;

    case (state_q)
      ST_WAIT: begin
        if (evt_acc) begin
          if (evt_on) begin
            if (on_hit) begin
              vst_d[on_idx] = V_ATTACK;
              vel_d[on_idx] = evt_vel;
              inc_d[on_idx] = evt_inc;
            end else if (free_hit) begin
              init_en  = 1'b1;
              init_idx = free_idx;
            end else begin
`ifdef VOICE_STEAL_EN
              init_en     = 1'b1;
              init_idx    = steal_ptr_q;
              steal_ptr_d = steal_ptr_q + VIDX_W'(1);
`else
              evt_drop_d  = 1'b1;
`endif
            end
          end else if (off_hit) begin
            vst_d[off_idx] = V_RELEASE;
          end
        end
        if (tick) begin
          state_d = ST_SCAN;
          vidx_d  = '0;
          acc_d   = '0;
        end
      end
      ST_SCAN: begin
        acc_d = acc_q + ACC_W'(contrib);
        if (vst_q[vidx_q] != V_IDLE)
          phase_d[vidx_q] = phase_q[vidx_q] + inc_q[vidx_q];
        case (vst_q[vidx_q])
          V_ATTACK:
            if (env_ext + ATK_R >= FULL_X) begin
              env_d[vidx_q] = ENV_FULL;
              vst_d[vidx_q] = V_DECAY;
            end else begin
              env_d[vidx_q] = ENV_W'(env_ext + ATK_R);
            end
          V_DECAY:
            if (env_ext <= SUS_X + DEC_R) begin
              env_d[vidx_q] = ENV_W'(SUS_X);
              vst_d[vidx_q] = V_SUSTAIN;
            end else begin
              env_d[vidx_q] = ENV_W'(env_ext - DEC_R);
            end
          V_RELEASE:
            if (env_ext <= REL_R) begin
              env_d[vidx_q] = '0;
              vst_d[vidx_q] = V_IDLE;
            end else begin
              env_d[vidx_q] = ENV_W'(env_ext - REL_R);
            end
          default: ;
        endcase
        vidx_d = vidx_q + VIDX_W'(1);
        if (vidx_q == VIDX_W'(NUM_VOICES - 1))
          state_d = ST_EMIT;
      end
      ST_EMIT: begin
        sample_out_d   = OUT_W'(acc_q) <<< OUT_SH;
        sample_valid_d = 1'b1;
        voices_act_d   = act_cnt;
        state_d        = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase

    if (init_en) begin
      vst_d[init_idx]   = V_ATTACK;
      phase_d[init_idx] = '0;
      env_d[init_idx]   = '0;
      note_d[init_idx]  = evt_note;
      chan_d[init_idx]  = evt_chan;
      vel_d[init_idx]   = evt_vel;
      inc_d[init_idx]   = evt_inc;
    end
  end

  always_ff @(posedge clk32) begin
    if (rst) begin
      state_q        <= ST_WAIT;
      cnt_q          <= '0;
      vidx_q         <= '0;
      acc_q          <= '0;
      sample_out_q   <= '0;
      sample_valid_q <= 1'b0;
      evt_drop_q     <= 1'b0;
      voices_act_q   <= '0;
`ifdef VOICE_STEAL_EN
      steal_ptr_q    <= '0;
`endif
      for (int i = 0; i < NUM_VOICES; i++) begin
        vst_q[i]   <= V_IDLE;
        phase_q[i] <= '0;
        inc_q[i]   <= '0;
        env_q[i]   <= '0;
        note_q[i]  <= '0;
        vel_q[i]   <= '0;
        chan_q[i]  <= '0;
      end
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      vidx_q         <= vidx_d;
      acc_q          <= acc_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      evt_drop_q     <= evt_drop_d;
      voices_act_q   <= voices_act_d;
`ifdef VOICE_STEAL_EN
      steal_ptr_q    <= steal_ptr_d;
`endif
      vst_q          <= vst_d;
      phase_q        <= phase_d;
      inc_q          <= inc_d;
      env_q          <= env_d;
      note_q         <= note_d;
      vel_q          <= vel_d;
      chan_q         <= chan_d;
    end
  end

endmodule
